// File: rtl/decode_stage_pipelined.sv
// Decode stage: register file with write-through bypass, forwarded branch
// compare, branch-target adder and an ID/EX pipeline register that the
// hazard unit can hold or flush.
//
// Pipeline handshake: the E side has no backpressure. valid_e = 1 marks a
// real instruction in E. hold_e freezes the ID/EX contents, flush_e replaces
// them with a bubble, and flush_e wins when both are high.
module decode_stage_pipelined #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int REG_COUNT   = 32,
  parameter int OP_WIDTH    = 5,
  parameter int IMM_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic [INSTR_WIDTH-1:0] pcplus4,
  input  logic                   jmp,
  input  logic                   branch,
  input  logic [1:0]             branch_mode,
  input  logic [1:0]             forward_a_d,
  input  logic [1:0]             forward_b_d,
  input  logic [DATA_WIDTH-1:0]  alu_out_m,
  input  logic [DATA_WIDTH-1:0]  result_w,
  input  logic [OP_WIDTH-1:0]    write_reg_w,
  input  logic                   reg_write_w,
  input  logic                   hold_e,
  input  logic                   flush_e,
  output logic [INSTR_WIDTH-1:0] pc_branch_d,
  output logic [1:0]             pc_src_d,
  output logic [DATA_WIDTH-1:0]  rd1_e,
  output logic [DATA_WIDTH-1:0]  rd2_e,
  output logic [DATA_WIDTH-1:0]  sign_imm_e,
  output logic [OP_WIDTH-1:0]    rs_e,
  output logic [OP_WIDTH-1:0]    rt_e,
  output logic [OP_WIDTH-1:0]    rd_e,
  output logic                   valid_e
);

  localparam logic [1:0] MODE_BEQ  = 2'b00;
  localparam logic [1:0] MODE_BNE  = 2'b01;
  localparam logic [1:0] MODE_BLEZ = 2'b10;
  localparam logic [1:0] MODE_BGTZ = 2'b11;

  localparam logic [1:0] FWD_ALU_M    = 2'b01;
  localparam logic [1:0] FWD_RESULT_W = 2'b10;

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  logic [OP_WIDTH-1:0]   rs_d, rt_d, rd_d;
  logic                  rs_ok, rt_ok, wr_ok;
  logic [DATA_WIDTH-1:0] rd1_d, rd2_d;
  logic [DATA_WIDTH-1:0] sign_imm_d;
  logic [INSTR_WIDTH-1:0] imm_pc;
  logic [DATA_WIDTH-1:0] cmp_a, cmp_b;
  logic                  taken;
  logic                  unused_instr_bits;

  // Opcode/funct bits above the rs field are decoded elsewhere.
  assign unused_instr_bits = &{1'b0, instruction[INSTR_WIDTH-1:26]};

  assign rs_d = instruction[21 +: OP_WIDTH];
  assign rt_d = instruction[16 +: OP_WIDTH];
  assign rd_d = instruction[11 +: OP_WIDTH];

  // Index range checks only exist when the index space is larger than the file.
  if (REG_COUNT < 2 ** OP_WIDTH) begin : g_range
    assign rs_ok = int'(rs_d) < REG_COUNT;
    assign rt_ok = int'(rt_d) < REG_COUNT;
    assign wr_ok = int'(write_reg_w) < REG_COUNT;
  end else begin : g_full
    assign rs_ok = 1'b1;
    assign rt_ok = 1'b1;
    assign wr_ok = 1'b1;
  end

  // Register file write port; R0 and out-of-range indices are never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (reg_write_w && (write_reg_w != '0) && wr_ok) begin
      regs[write_reg_w] <= result_w;
    end
  end

  // Read ports: zero for R0/out-of-range, write-through bypass from W.
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if ((rs_d != '0) && rs_ok) begin
      if (reg_write_w && (write_reg_w == rs_d)) rd1_d = result_w;
      else                                      rd1_d = regs[rs_d];
    end
    if ((rt_d != '0) && rt_ok) begin
      if (reg_write_w && (write_reg_w == rt_d)) rd2_d = result_w;
      else                                      rd2_d = regs[rt_d];
    end
  end

  assign sign_imm_d = {{(DATA_WIDTH-IMM_WIDTH){instruction[IMM_WIDTH-1]}},
                       instruction[IMM_WIDTH-1:0]};
  assign imm_pc     = {{(INSTR_WIDTH-IMM_WIDTH){instruction[IMM_WIDTH-1]}},
                       instruction[IMM_WIDTH-1:0]};

  // Branch target wraps modulo 2**INSTR_WIDTH.
  assign pc_branch_d = pcplus4 + (imm_pc << 2);

  // Compare operands: forwarded values feed the branch compare only.
  always_comb begin
    case (forward_a_d)
      FWD_ALU_M:    cmp_a = alu_out_m;
      FWD_RESULT_W: cmp_a = result_w;
      default:      cmp_a = rd1_d;
    endcase
    case (forward_b_d)
      FWD_ALU_M:    cmp_b = alu_out_m;
      FWD_RESULT_W: cmp_b = result_w;
      default:      cmp_b = rd2_d;
    endcase
  end

  // Branch resolution; BLEZ/BGTZ look at operand A only.
  always_comb begin
    case (branch_mode)
      MODE_BEQ:  taken = (cmp_a == cmp_b);
      MODE_BNE:  taken = (cmp_a != cmp_b);
      MODE_BLEZ: taken = cmp_a[DATA_WIDTH-1] || (cmp_a == '0);
      MODE_BGTZ: taken = !cmp_a[DATA_WIDTH-1] && (cmp_a != '0);
      default:   taken = 1'b0;
    endcase
  end

  assign pc_src_d = {jmp, branch & taken};

  // ID/EX register: flush beats hold, otherwise capture the D-side values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1_e      <= '0;
      rd2_e      <= '0;
      sign_imm_e <= '0;
      rs_e       <= '0;
      rt_e       <= '0;
      rd_e       <= '0;
      valid_e    <= 1'b0;
    end else if (flush_e) begin
      rd1_e      <= '0;
      rd2_e      <= '0;
      sign_imm_e <= '0;
      rs_e       <= '0;
      rt_e       <= '0;
      rd_e       <= '0;
      valid_e    <= 1'b0;
    end else if (!hold_e) begin
      rd1_e      <= rd1_d;
      rd2_e      <= rd2_d;
      sign_imm_e <= sign_imm_d;
      rs_e       <= rs_d;
      rt_e       <= rt_d;
      rd_e       <= rd_d;
      valid_e    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Bench for decode_stage_pipelined: a reference regfile model predicts the
// ID/EX contents, which are queued at drive time and compared after the edge.
module tb_decode_stage_pipelined;

  localparam int EW = 1 + 32 * 3 + 5 * 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction, pcplus4;
  logic        jmp, branch;
  logic [1:0]  branch_mode, forward_a_d, forward_b_d;
  logic [31:0] alu_out_m, result_w;
  logic [4:0]  write_reg_w;
  logic        reg_write_w, hold_e, flush_e;
  logic [31:0] pc_branch_d;
  logic [1:0]  pc_src_d;
  logic [31:0] rd1_e, rd2_e, sign_imm_e;
  logic [4:0]  rs_e, rt_e, rd_e;
  logic        valid_e;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp;
  logic [31:0]   model [32];
  logic [EW-1:0] e_bus;
  int tests_run = 0;
  int tests_failed = 0;

  assign e_bus = {valid_e, rd1_e, rd2_e, sign_imm_e, rs_e, rt_e, rd_e};

  decode_stage_pipelined dut (
    .clk(clk), .reset(reset), .instruction(instruction), .pcplus4(pcplus4),
    .jmp(jmp), .branch(branch), .branch_mode(branch_mode),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .alu_out_m(alu_out_m), .result_w(result_w), .write_reg_w(write_reg_w),
    .reg_write_w(reg_write_w), .hold_e(hold_e), .flush_e(flush_e),
    .pc_branch_d(pc_branch_d), .pc_src_d(pc_src_d), .rd1_e(rd1_e),
    .rd2_e(rd2_e), .sign_imm_e(sign_imm_e), .rs_e(rs_e), .rt_e(rt_e),
    .rd_e(rd_e), .valid_e(valid_e)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (reg_write_w && (write_reg_w == idx)) return result_w;
    return model[idx];
  endfunction

  function automatic logic [EW-1:0] mk_e();
    logic [4:0] rs, rt, rd;
    logic [31:0] imm;
    rs  = instruction[25:21];
    rt  = instruction[20:16];
    rd  = instruction[15:11];
    imm = {{16{instruction[15]}}, instruction[15:0]};
    return {1'b1, mread(rs), mread(rt), imm, rs, rt, rd};
  endfunction

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    instruction = {6'b000100, rs, rt, imm};
  endtask

  // One clock of the ID/EX register with the currently driven inputs.
  task automatic step();
    logic [EW-1:0] e;
    if (flush_e)     e = '0;
    else if (hold_e) e = last_exp;
    else             e = mk_e();
    exp_q.push_back(e);
    last_exp = e;
    @(posedge clk);
    if (reg_write_w && (write_reg_w != 5'd0)) model[write_reg_w] = result_w;
    #1;
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
    reg_write_w = 1'b1;
    write_reg_w = idx;
    result_w    = val;
    step();
    void'(exp_q.pop_front());
    reg_write_w = 1'b0;
  endtask

  task automatic test_reset();
    logic [EW-1:0] exp;
    reset = 1'b1;
    #1;
    tests_run++;
    if (e_bus !== '0) begin
      tests_failed++;
      $display("FAIL reset_e: got %h expected 0", e_bus);
    end
    #20;
    reset = 1'b0;
    @(posedge clk);
    #1;
    set_instr(5'd5, 5'd6, 16'h0000);
    step();
    exp = exp_q.pop_front();
    tests_run++;
    if (e_bus !== exp || rd1_e !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_regfile: got %h expected %h", e_bus, exp);
    end
  endtask

  task automatic test_write_read();
    logic [EW-1:0] exp;
    set_instr(5'd0, 5'd0, 16'h0000);
    write_reg(5'd5, 32'h1234);
    set_instr(5'd5, 5'd0, 16'h0010);
    step();
    exp = exp_q.pop_front();
    tests_run++;
    if (e_bus !== exp || rd1_e !== 32'h1234 || valid_e !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_read: got %h expected %h", e_bus, exp);
    end
  endtask

  task automatic test_bypass();
    logic [EW-1:0] exp;
    set_instr(5'd7, 5'd5, 16'h8000);
    reg_write_w = 1'b1; write_reg_w = 5'd7; result_w = 32'hAA;
    step();
    exp = exp_q.pop_front();
    tests_run++;
    if (e_bus !== exp || rd1_e !== 32'hAA || sign_imm_e !== 32'hFFFF8000) begin
      tests_failed++;
      $display("FAIL bypass: got %h expected %h", e_bus, exp);
    end
    set_instr(5'd0, 5'd0, 16'h0000);
    write_reg_w = 5'd0; result_w = 32'h55;
    step();
    exp = exp_q.pop_front();
    tests_run++;
    if (e_bus !== exp || rd1_e !== 32'd0 || rd2_e !== 32'd0) begin
      tests_failed++;
      $display("FAIL r0_same_cycle: got %h expected %h", e_bus, exp);
    end
    reg_write_w = 1'b0;
    step();
    exp = exp_q.pop_front();
    tests_run++;
    if (e_bus !== exp || rd1_e !== 32'd0) begin
      tests_failed++;
      $display("FAIL r0_after_write: got %h expected %h", e_bus, exp);
    end
  endtask

  task automatic test_branch_modes();
    logic [1:0] exp_src [5];
    logic [4:0] rs_t [5];
    logic [4:0] rt_t [5];
    logic [1:0] mode_t [5];
    logic       jmp_t [5];
    write_reg(5'd3, 32'd3);
    write_reg(5'd8, 32'd3);
    write_reg(5'd10, 32'hFFFFFFFF);
    rs_t = '{5'd3, 5'd3, 5'd10, 5'd0, 5'd3};
    rt_t = '{5'd8, 5'd8, 5'd0, 5'd10, 5'd8};
    mode_t = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    jmp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_src = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b11};
    branch = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_instr(rs_t[i], rt_t[i], 16'h0004);
      branch_mode = mode_t[i];
      jmp = jmp_t[i];
      #1;
      tests_run++;
      if (pc_src_d !== exp_src[i]) begin
        tests_failed++;
        $display("FAIL branch_mode_%0d: got %b expected %b", i, pc_src_d, exp_src[i]);
      end
    end
    branch = 1'b0; jmp = 1'b0;
    set_instr(5'd3, 5'd8, 16'h0004);
    branch_mode = 2'b00;
    #1;
    tests_run++;
    if (pc_src_d !== 2'b00) begin
      tests_failed++;
      $display("FAIL branch_gated: got %b expected 00", pc_src_d);
    end
  endtask

  task automatic test_forwarding();
    logic [EW-1:0] exp;
    write_reg(5'd4, 32'd4);
    write_reg(5'd9, 32'd9);
    set_instr(5'd4, 5'd9, 16'h0000);
    branch = 1'b1; branch_mode = 2'b00;
    forward_a_d = 2'b01; alu_out_m = 32'd9;
    #1;
    tests_run++;
    if (pc_src_d !== 2'b01) begin
      tests_failed++;
      $display("FAIL fwd_alu_m: got %b expected 01", pc_src_d);
    end
    forward_a_d = 2'b10; result_w = 32'd9; alu_out_m = 32'd0;
    #1;
    tests_run++;
    if (pc_src_d !== 2'b01) begin
      tests_failed++;
      $display("FAIL fwd_result_w: got %b expected 01", pc_src_d);
    end
    forward_a_d = 2'b11;
    #1;
    tests_run++;
    if (pc_src_d !== 2'b00) begin
      tests_failed++;
      $display("FAIL fwd_regfile_11: got %b expected 00", pc_src_d);
    end
    forward_a_d = 2'b00; forward_b_d = 2'b01; alu_out_m = 32'd4;
    #1;
    tests_run++;
    if (pc_src_d !== 2'b01) begin
      tests_failed++;
      $display("FAIL fwd_b_alu_m: got %b expected 01", pc_src_d);
    end
    forward_a_d = 2'b01; forward_b_d = 2'b00; alu_out_m = 32'd9;
    step();
    exp = exp_q.pop_front();
    tests_run++;
    if (e_bus !== exp || rd1_e !== 32'd4 || rd2_e !== 32'd9) begin
      tests_failed++;
      $display("FAIL fwd_not_captured: got %h expected %h", e_bus, exp);
    end
    forward_a_d = 2'b00; branch = 1'b0;
  endtask

  task automatic test_branch_target();
    set_instr(5'd0, 5'd0, 16'hFFFF);
    pcplus4 = 32'h100;
    #1;
    tests_run++;
    if (pc_branch_d !== 32'hFC) begin
      tests_failed++;
      $display("FAIL target_neg: got %h expected 000000fc", pc_branch_d);
    end
    set_instr(5'd0, 5'd0, 16'h0001);
    pcplus4 = 32'hFFFFFFFC;
    #1;
    tests_run++;
    if (pc_branch_d !== 32'h0) begin
      tests_failed++;
      $display("FAIL target_wrap: got %h expected 00000000", pc_branch_d);
    end
    for (int i = 0; i < 4; i++) begin
      logic [15:0] imm;
      logic [31:0] pc, exp_t;
      imm = 16'($urandom_range(0, 16'hFFFF));
      pc  = $urandom;
      exp_t = pc + ({{16{imm[15]}}, imm} * 32'd4);
      set_instr(5'd0, 5'd0, imm);
      pcplus4 = pc;
      #1;
      tests_run++;
      if (pc_branch_d !== exp_t) begin
        tests_failed++;
        $display("FAIL target_rand_%0d: got %h expected %h", i, pc_branch_d, exp_t);
      end
    end
  endtask

  task automatic test_hold_flush();
    logic [EW-1:0] exp;
    write_reg(5'd3, 32'h33);
    set_instr(5'd3, 5'd4, 16'h1234);
    step();
    exp = exp_q.pop_front();
    tests_run++;
    if (e_bus !== exp) begin
      tests_failed++;
      $display("FAIL hold_setup: got %h expected %h", e_bus, exp);
    end
    set_instr(5'd9, 5'd10, 16'h5678);
    hold_e = 1'b1;
    reg_write_w = 1'b1; write_reg_w = 5'd12; result_w = 32'h77;
    for (int i = 0; i < 2; i++) begin
      step();
      reg_write_w = 1'b0;
      exp = exp_q.pop_front();
      tests_run++;
      if (e_bus !== exp || rd1_e !== 32'h33 || rs_e !== 5'd3) begin
        tests_failed++;
        $display("FAIL hold_cycle_%0d: got %h expected %h", i, e_bus, exp);
      end
    end
    flush_e = 1'b1;
    step();
    exp = exp_q.pop_front();
    tests_run++;
    if (e_bus !== exp || valid_e !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_over_hold: got %h expected %h", e_bus, exp);
    end
    flush_e = 1'b0; hold_e = 1'b0;
    set_instr(5'd12, 5'd3, 16'h0000);
    step();
    exp = exp_q.pop_front();
    tests_run++;
    if (e_bus !== exp || rd1_e !== 32'h77) begin
      tests_failed++;
      $display("FAIL write_in_hold: got %h expected %h", e_bus, exp);
    end
    hold_e = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (e_bus !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_hold: got %h expected 0", e_bus);
    end
    #4;
    reset = 1'b0;
    hold_e = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    last_exp = '0;
    @(posedge clk);
    #1;
    set_instr(5'd12, 5'd3, 16'h0000);
    step();
    exp = exp_q.pop_front();
    tests_run++;
    if (e_bus !== exp || rd1_e !== 32'd0 || rd2_e !== 32'd0) begin
      tests_failed++;
      $display("FAIL regfile_after_reset: got %h expected %h", e_bus, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] exp;
    for (int i = 0; i < 12; i++) begin
      logic [4:0] rs, rt;
      rs = 5'($urandom_range(0, 31));
      rt = 5'($urandom_range(0, 31));
      set_instr(rs, rt, 16'($urandom_range(0, 16'hFFFF)));
      reg_write_w = 1'($urandom_range(0, 1));
      write_reg_w = 5'($urandom_range(0, 31));
      result_w = $urandom;
      step();
      exp = exp_q.pop_front();
      tests_run++;
      if (e_bus !== exp) begin
        tests_failed++;
        $display("FAIL b2b_%0d: got %h expected %h", i, e_bus, exp);
      end
    end
    reg_write_w = 1'b0;
  endtask

  initial begin
    instruction = '0; pcplus4 = '0; jmp = 1'b0; branch = 1'b0;
    branch_mode = 2'b00; forward_a_d = 2'b00; forward_b_d = 2'b00;
    alu_out_m = '0; result_w = '0; write_reg_w = '0; reg_write_w = 1'b0;
    hold_e = 1'b0; flush_e = 1'b0; reset = 1'b0;
    last_exp = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    test_reset();
    test_write_read();
    test_bypass();
    test_branch_modes();
    test_forwarding();
    test_branch_target();
    test_hold_flush();
    test_back_to_back();

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
